// File: rtl/apb_ucpd_tx_fsm_if.sv
// Handshake bundle between the UCPD TX sequencer and its SW/PHY-side driver.
// The master drives commands and bit timing; the slave (the sequencer) drives phase enables and pulses.
interface apb_ucpd_tx_fsm_if;
    logic       ucpd_en;
    logic       bit_clk_red;
    logic       transmit_en;
    logic       tx_hrst;
    logic [1:0] tx_mode;
    logic [9:0] tx_paysz;

    logic       pre_en;
    logic       sop_en;
    logic       data_en;
    logic       crc_en;
    logic       eop_en;
    logic       bmc_en;
    logic       bist_en;
    logic       tx_sop_cmplt;
    logic       tx_data_cmplt;
    logic       tx_crc_cmplt;
    logic       tx_eop_cmplt;
    logic       tx_wait_cmplt;
    logic       txfifo_ld_en;
    logic       txdr_req;
    logic       tx_msg_disc;
    logic       tx_hrst_disc;
    logic       tx_busy;

    modport master (
        output ucpd_en, bit_clk_red, transmit_en, tx_hrst, tx_mode, tx_paysz,
        input  pre_en, sop_en, data_en, crc_en, eop_en, bmc_en, bist_en,
               tx_sop_cmplt, tx_data_cmplt, tx_crc_cmplt, tx_eop_cmplt, tx_wait_cmplt,
               txfifo_ld_en, txdr_req, tx_msg_disc, tx_hrst_disc, tx_busy
    );

    modport slave (
        input  ucpd_en, bit_clk_red, transmit_en, tx_hrst, tx_mode, tx_paysz,
        output pre_en, sop_en, data_en, crc_en, eop_en, bmc_en, bist_en,
               tx_sop_cmplt, tx_data_cmplt, tx_crc_cmplt, tx_eop_cmplt, tx_wait_cmplt,
               txfifo_ld_en, txdr_req, tx_msg_disc, tx_hrst_disc, tx_busy
    );
endinterface

// File: rtl/apb_ucpd_tx_fsm.sv
// USB-PD UCPD transmit sequencer: turns SW send / hard-reset commands into one-hot
// phase enables, completion pulses, TX byte handshakes and discard indications.
module apb_ucpd_tx_fsm #(
    parameter int IFG_BITS = 30
) (
    input logic               ic_clk,
    input logic               ic_rst_n,
    apb_ucpd_tx_fsm_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_SOP, S_DATA, S_CRC, S_EOP, S_WAIT} state_t;

    localparam logic [6:0] L_WAIT_LAST = 7'(IFG_BITS - 1);

    state_t     r_state, w_state_nxt;
    logic [6:0] r_cnt, w_cnt_nxt;
    logic [9:0] r_loaded, w_loaded_nxt;
    logic [9:0] r_paysz, w_paysz_nxt;
    logic [1:0] r_mode, w_mode_nxt;
    logic       r_hrst_act, w_hrst_act_nxt;
    logic       r_crst_act, w_crst_act_nxt;
    logic       r_sop_cmplt, w_sop_cmplt_nxt;
    logic       r_data_cmplt, w_data_cmplt_nxt;
    logic       r_crc_cmplt, w_crc_cmplt_nxt;
    logic       r_eop_cmplt, w_eop_cmplt_nxt;
    logic       r_wait_cmplt, w_wait_cmplt_nxt;
    logic       r_ld_en, w_ld_en_nxt;
    logic       r_txdr_req, w_txdr_req_nxt;
    logic       r_msg_disc, w_msg_disc_nxt;
    logic       r_hrst_disc, w_hrst_disc_nxt;
    logic       r_te_q, r_te_d, r_hr_q, r_hr_d;
    logic       w_te_rise, w_hr_rise, w_bist, w_busy, w_bit;

    assign w_te_rise = r_te_q & ~r_te_d;
    assign w_hr_rise = r_hr_q & ~r_hr_d;
    assign w_bist    = (r_mode == 2'b10);
    assign w_busy    = (r_state != S_IDLE);
    assign w_bit     = bus.bit_clk_red;

    always_ff @(posedge ic_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_loaded     <= '0;
            r_paysz      <= '0;
            r_mode       <= '0;
            r_hrst_act   <= 1'b0;
            r_crst_act   <= 1'b0;
            r_sop_cmplt  <= 1'b0;
            r_data_cmplt <= 1'b0;
            r_crc_cmplt  <= 1'b0;
            r_eop_cmplt  <= 1'b0;
            r_wait_cmplt <= 1'b0;
            r_ld_en      <= 1'b0;
            r_txdr_req   <= 1'b0;
            r_msg_disc   <= 1'b0;
            r_hrst_disc  <= 1'b0;
            r_te_q       <= 1'b0;
            r_te_d       <= 1'b0;
            r_hr_q       <= 1'b0;
            r_hr_d       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_loaded     <= w_loaded_nxt;
            r_paysz      <= w_paysz_nxt;
            r_mode       <= w_mode_nxt;
            r_hrst_act   <= w_hrst_act_nxt;
            r_crst_act   <= w_crst_act_nxt;
            r_sop_cmplt  <= w_sop_cmplt_nxt;
            r_data_cmplt <= w_data_cmplt_nxt;
            r_crc_cmplt  <= w_crc_cmplt_nxt;
            r_eop_cmplt  <= w_eop_cmplt_nxt;
            r_wait_cmplt <= w_wait_cmplt_nxt;
            r_ld_en      <= w_ld_en_nxt;
            r_txdr_req   <= w_txdr_req_nxt;
            r_msg_disc   <= w_msg_disc_nxt;
            r_hrst_disc  <= w_hrst_disc_nxt;
            r_te_q       <= bus.transmit_en;
            r_te_d       <= r_te_q;
            r_hr_q       <= bus.tx_hrst;
            r_hr_d       <= r_hr_q;
        end
    end

    // Phase progression first; later blocks override it in rising priority
    // (transmit_en rise, then tx_hrst rise, then ucpd_en low).
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = w_bit ? r_cnt + 7'd1 : r_cnt;
        w_loaded_nxt     = r_loaded;
        w_paysz_nxt      = r_paysz;
        w_mode_nxt       = r_mode;
        w_hrst_act_nxt   = r_hrst_act;
        w_crst_act_nxt   = r_crst_act;
        w_sop_cmplt_nxt  = 1'b0;
        w_data_cmplt_nxt = 1'b0;
        w_crc_cmplt_nxt  = 1'b0;
        w_eop_cmplt_nxt  = 1'b0;
        w_wait_cmplt_nxt = 1'b0;
        w_ld_en_nxt      = 1'b0;
        w_txdr_req_nxt   = r_ld_en && (r_loaded < r_paysz);
        w_msg_disc_nxt   = 1'b0;
        w_hrst_disc_nxt  = 1'b0;

        case (r_state)
            S_IDLE: w_cnt_nxt = '0;
            S_PRE: begin
                // BIST keeps wrapping the 7-bit counter while SW holds transmit_en
                if (w_bit && r_cnt == 7'd127 && !(w_bist && r_te_q)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_bist ? S_IDLE : S_SOP;
                    if (w_bist) w_mode_nxt = '0;
                end
            end
            S_SOP: begin
                if (w_bit && r_cnt == 7'd19) begin
                    w_cnt_nxt       = '0;
                    w_sop_cmplt_nxt = 1'b1;
                    if (r_hrst_act || r_crst_act) begin
                        w_state_nxt = S_WAIT;
                    end else if (r_paysz == '0) begin
                        w_state_nxt      = S_CRC;
                        w_data_cmplt_nxt = 1'b1;
                    end else begin
                        w_state_nxt  = S_DATA;
                        w_ld_en_nxt  = 1'b1;
                        w_loaded_nxt = 10'd1;
                    end
                end
            end
            S_DATA: begin
                // The counter tracks bits within the current byte only
                if (w_bit && r_cnt == 7'd9) begin
                    w_cnt_nxt = '0;
                    if (r_loaded >= r_paysz) begin
                        w_state_nxt      = S_CRC;
                        w_data_cmplt_nxt = 1'b1;
                    end else begin
                        w_ld_en_nxt  = 1'b1;
                        w_loaded_nxt = r_loaded + 10'd1;
                    end
                end
            end
            S_CRC: begin
                if (w_bit && r_cnt == 7'd39) begin
                    w_cnt_nxt       = '0;
                    w_state_nxt     = S_EOP;
                    w_crc_cmplt_nxt = 1'b1;
                end
            end
            S_EOP: begin
                if (w_bit && r_cnt == 7'd4) begin
                    w_cnt_nxt       = '0;
                    w_state_nxt     = S_WAIT;
                    w_eop_cmplt_nxt = 1'b1;
                end
            end
            S_WAIT: begin
                if (w_bit && r_cnt == L_WAIT_LAST) begin
                    w_cnt_nxt        = '0;
                    w_state_nxt      = S_IDLE;
                    w_wait_cmplt_nxt = 1'b1;
                    w_hrst_act_nxt   = 1'b0;
                    w_crst_act_nxt   = 1'b0;
                    w_loaded_nxt     = '0;
                    w_mode_nxt       = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        if (w_te_rise) begin
            if (w_busy || w_hr_rise) begin
                w_msg_disc_nxt = 1'b1;
            end else if (bus.tx_mode == 2'b11) begin
                w_msg_disc_nxt = 1'b1;
            end else begin
                w_state_nxt    = S_PRE;
                w_cnt_nxt      = '0;
                w_mode_nxt     = bus.tx_mode;
                w_paysz_nxt    = bus.tx_paysz;
                w_loaded_nxt   = '0;
                w_hrst_act_nxt = 1'b0;
                w_crst_act_nxt = (bus.tx_mode == 2'b01);
                w_txdr_req_nxt = (bus.tx_mode == 2'b00) && (bus.tx_paysz != '0);
            end
        end

        if (w_hr_rise) begin
            if (r_hrst_act || r_crst_act) begin
                w_hrst_disc_nxt = 1'b1;
            end else begin
                w_state_nxt      = S_PRE;
                w_cnt_nxt        = '0;
                w_mode_nxt       = '0;
                w_paysz_nxt      = '0;
                w_loaded_nxt     = '0;
                w_hrst_act_nxt   = 1'b1;
                w_crst_act_nxt   = 1'b0;
                w_sop_cmplt_nxt  = 1'b0;
                w_data_cmplt_nxt = 1'b0;
                w_crc_cmplt_nxt  = 1'b0;
                w_eop_cmplt_nxt  = 1'b0;
                w_wait_cmplt_nxt = 1'b0;
                w_ld_en_nxt      = 1'b0;
                w_txdr_req_nxt   = 1'b0;
            end
        end

        if (!bus.ucpd_en) begin
            w_state_nxt      = S_IDLE;
            w_cnt_nxt        = '0;
            w_loaded_nxt     = '0;
            w_paysz_nxt      = '0;
            w_mode_nxt       = '0;
            w_hrst_act_nxt   = 1'b0;
            w_crst_act_nxt   = 1'b0;
            w_sop_cmplt_nxt  = 1'b0;
            w_data_cmplt_nxt = 1'b0;
            w_crc_cmplt_nxt  = 1'b0;
            w_eop_cmplt_nxt  = 1'b0;
            w_wait_cmplt_nxt = 1'b0;
            w_ld_en_nxt      = 1'b0;
            w_txdr_req_nxt   = 1'b0;
            w_msg_disc_nxt   = 1'b0;
            w_hrst_disc_nxt  = 1'b0;
        end
    end

    assign bus.pre_en        = (r_state == S_PRE);
    assign bus.sop_en        = (r_state == S_SOP);
    assign bus.data_en       = (r_state == S_DATA);
    assign bus.crc_en        = (r_state == S_CRC);
    assign bus.eop_en        = (r_state == S_EOP);
    assign bus.bmc_en        = (r_state != S_IDLE) && (r_state != S_WAIT);
    assign bus.bist_en       = (r_state == S_PRE) && w_bist;
    assign bus.tx_sop_cmplt  = r_sop_cmplt;
    assign bus.tx_data_cmplt = r_data_cmplt;
    assign bus.tx_crc_cmplt  = r_crc_cmplt;
    assign bus.tx_eop_cmplt  = r_eop_cmplt;
    assign bus.tx_wait_cmplt = r_wait_cmplt;
    assign bus.txfifo_ld_en  = r_ld_en;
    assign bus.txdr_req      = r_txdr_req;
    assign bus.tx_msg_disc   = r_msg_disc;
    assign bus.tx_hrst_disc  = r_hrst_disc;
    assign bus.tx_busy       = w_busy;
endmodule

// File: doc/apb_ucpd_tx_fsm.md
# apb_ucpd_tx_fsm

USB-PD UCPD transmit sequencer that sits directly upstream of the TX data/shift stage. It converts SW commands (`transmit_en`, `tx_hrst`, `tx_mode`, `tx_paysz`) into one-hot phase enables (preamble, SOP, data, CRC, EOP), per-phase completion pulses, TX-register handshakes and discard indications. All phase lengths are counted in bit periods marked by the `bit_clk_red` pulse.

## Interface
- `IFG_BITS`, 30, inter-frame gap length in bit periods (WAIT phase); legal range 1..127.
- `ic_clk`  in  1  processor clock.
- `ic_rst_n`  in  1  asynchronous, active-low reset.
- `ucpd_en`  in  1  block enable; low forces IDLE synchronously.
- `bit_clk_red`  in  1  one-`ic_clk`-wide pulse per bit period.
- `transmit_en`  in  1  SW TXSEND level; its rising edge starts a transmission.
- `tx_hrst`  in  1  SW TXHRST level; its rising edge requests a hard reset.
- `tx_mode`  in  2  00 normal message, 01 cable reset, 10 BIST carrier, 11 reserved.
- `tx_paysz`  in  10  payload byte count, sampled at start.
- `pre_en`, `sop_en`, `data_en`, `crc_en`, `eop_en`  out  1 each  phase enables, at most one high.
- `bmc_en`  out  1  high in PRE..EOP.
- `bist_en`  out  1  high in PRE when BIST mode is latched.
- `tx_sop_cmplt`, `tx_data_cmplt`, `tx_crc_cmplt`, `tx_eop_cmplt`, `tx_wait_cmplt`  out  1 each  one-cycle completion pulses.
- `txfifo_ld_en`  out  1  pulse that loads the next encoded byte into the data shifter.
- `txdr_req`  out  1  pulse requesting the next byte from SW.
- `tx_msg_disc`, `tx_hrst_disc`  out  1 each  discard pulses.
- `tx_busy`  out  1  state != IDLE.

## Operation
- States: IDLE, PRE (128 bits), SOP (20), DATA (10×bytes), CRC (40), EOP (5), WAIT (`IFG_BITS`).
- Bit counter, 7 bits: increments on `bit_clk_red` and clears on every state change.
- A phase ends on the `bit_clk_red` cycle where count == length−1. On that edge the state advances, the counter clears, and the matching `_cmplt` pulse is registered for one cycle.
- Edge detect: `transmit_en` and `tx_hrst` are registered internally. Rise = current & ~registered.
- On start, `tx_mode` and `tx_paysz` are latched, along with `hrst_act` (hard reset in progress) and `crst_act` (cable reset in progress).
- Normal sequence: IDLE → PRE → SOP → DATA → CRC → EOP → WAIT → IDLE.
- `tx_paysz` == 0: SOP → CRC directly, and `tx_data_cmplt` still pulses at the SOP end.
- Hard reset (`tx_hrst` rise) and cable reset (mode 01): PRE → SOP → WAIT → IDLE. For hard reset the SOP is the hard-reset ordered set.
- BIST (mode 10): PRE repeats (counter wraps at 127) while `transmit_en` is high.
  - After `transmit_en` falls, the current 128-bit block completes, then the FSM goes to IDLE.
  - No SOP/WAIT pulses are generated in BIST.
- Mode 11 at start: stay in IDLE and pulse `tx_msg_disc`.
- Byte handshake, with byte counter `loaded` (10 bits):
  - `txdr_req` pulses in the first PRE cycle when `tx_paysz` != 0.
  - `txfifo_ld_en` pulses in the first DATA cycle, and in the cycle after each 10th data bit while `loaded` < `tx_paysz`; `loaded` increments with each pulse.
  - `txdr_req` pulses the cycle after each `txfifo_ld_en` while `loaded` < `tx_paysz`.
- Priority, highest first: `ucpd_en` low, `tx_hrst` rise, `transmit_en` rise, phase completion.
- `tx_hrst` rise in IDLE, or in PRE/SOP/DATA/CRC/EOP/WAIT of a normal message: go to PRE with `hrst_act`=1 and counters cleared, aborting the message.
- `tx_hrst` rise while `hrst_act` or `crst_act` is set: pulse `tx_hrst_disc`, no state change.
- `transmit_en` rise while `tx_busy`: pulse `tx_msg_disc`, no state change.
- `hrst_act`/`crst_act` clear on return to IDLE.

## Timing
- Reset, and `ucpd_en` low, give: state IDLE, all counters 0, every output 0.
- Start latency: `transmit_en` rise sampled at edge N makes `pre_en`=1 and `txdr_req`=1 after edge N+1.
- Enables are decoded from the registered state and are glitch-free.
- The enable changes on the same edge that registers the `_cmplt` pulse.
- `txfifo_ld_en` precedes the first data-phase `bit_clk_red` by at least one cycle.
- Simultaneous `tx_hrst` rise and `transmit_en` rise in IDLE: the hard reset wins and `tx_msg_disc` pulses.
- Total normal-frame length: 193 + 10×`tx_paysz` + `IFG_BITS` bit periods.

## Test plan
- Normal, `tx_paysz`=2, `bit_clk_red` every 4 clocks → phase lengths of 128/20/20/40/5/30 bit pulses; `txdr_req` ×2; `txfifo_ld_en` ×2, 40 clocks apart; `tx_wait_cmplt` once.
- `tx_paysz`=0 → `data_en` never high; `tx_data_cmplt` coincides with `tx_sop_cmplt`; CRC follows immediately.
- `tx_hrst` rise at data bit 15 → PRE restarts within one clock; sequence PRE/SOP/WAIT; a second `tx_hrst` rise during that PRE → `tx_hrst_disc`=1.
- Cable reset, mode 01 → 128 + 20 + 30 bits, no DATA/CRC/EOP, `tx_sop_cmplt` once.
- BIST: `transmit_en` held for 300 bits → `bist_en` high for 384 bits (3 full blocks), then IDLE.
- `transmit_en` rise during CRC → `tx_msg_disc` pulse; `ucpd_en` dropped in DATA → IDLE next clock with all outputs 0.
